// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory bridge (dmem_bridge).
// Optional timeout support is enabled by defining DMEM_TIMEOUT_EN.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        REQ    = 2'b01,
        WAIT_R = 2'b10,
        DONE   = 2'b11
    } state_t;

    localparam logic [31:0] BUS_ERR_DATA = 32'hDEADBEEF;

    // The reserved encoding 2'b11 behaves as a word access.
    function automatic size_t decode_size(input logic [1:0] raw);
        size_t sz;
        case (raw)
            2'b00:   sz = SZ_BYTE;
            2'b01:   sz = SZ_HALF;
            default: sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    function automatic logic is_misaligned(input size_t sz, input logic [1:0] off);
        logic bad;
        case (sz)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            default: bad = |off;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_bridge_lane.sv
// Byte-lane steering for dmem_bridge: store enables/replication and load
// lane selection with sign or zero extension.
module dmem_lane
    import dmem_pkg::*;
(
    input  size_t       size,
    input  logic        sgn,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed byte and half-word out of the returned word.
    always_comb begin
        case (off)
            2'b00:   byte_s = rword[7:0];
            2'b01:   byte_s = rword[15:8];
            2'b10:   byte_s = rword[23:16];
            default: byte_s = rword[31:24];
        endcase
        if (off[1]) begin
            half_s = rword[31:16];
        end else begin
            half_s = rword[15:0];
        end
    end

    // Size-dependent enables, store replication and load extension.
    always_comb begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rword;
        case (size)
            SZ_BYTE: begin
                be        = 4'b0001 << off;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{sgn & byte_s[7]}}, byte_s};
            end
            SZ_HALF: begin
                be        = 4'b0011 << off;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{sgn & half_s[15]}}, half_s};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = wdata;
                rdata_ext = rword;
            end
        endcase
    end

endmodule

// File: rtl/dmem_bridge.sv
// Data-memory bridge between the single-cycle datapath and a handshaked bus.
// Define DMEM_TIMEOUT_EN to abort stuck accesses after TIMEOUT_CYCLES.
module dmem_bridge
    import dmem_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [31:0] RST_RDATA      = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misalign,
    output logic        bus_err,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    state_t      state_q, state_d;
    logic        mem_valid_q, mem_valid_d, mem_we_q, mem_we_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    size_t       size_q, size_d;
    logic        sgn_q, sgn_d;
    logic [1:0]  off_q, off_d;

    logic        req_s, mis_s;
    size_t       req_size_s, lane_size_s;
    logic        lane_sgn_s;
    logic [1:0]  lane_off_s;
    logic [3:0]  lane_be_s;
    logic [31:0] lane_wdata_s, lane_rdata_s;

    assign req_s      = req_read | req_write;
    assign req_size_s = decode_size(req_size);
    assign mis_s      = is_misaligned(req_size_s, addr[1:0]);
    assign stall      = req_s & ~mis_s & (state_q != DONE);
    assign misalign   = req_s & mis_s & (state_q == IDLE);

    assign rdata     = rdata_q;
    assign mem_valid = mem_valid_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Lanes follow the live request in IDLE and the captured one afterwards.
    always_comb begin
        if (state_q == IDLE) begin
            lane_size_s = req_size_s;
            lane_sgn_s  = req_signed;
            lane_off_s  = addr[1:0];
        end else begin
            lane_size_s = size_q;
            lane_sgn_s  = sgn_q;
            lane_off_s  = off_q;
        end
    end

    dmem_lane u_lane (
        .size      (lane_size_s),
        .sgn       (lane_sgn_s),
        .off       (lane_off_s),
        .wdata     (wdata),
        .rword     (mem_rdata),
        .be        (lane_be_s),
        .wdata_rep (lane_wdata_s),
        .rdata_ext (lane_rdata_s)
    );

`ifdef DMEM_TIMEOUT_EN
    localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             bus_err_q, bus_err_d, tmo_hit_s;
    assign tmo_hit_s = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    assign bus_err   = bus_err_q;
`else
    logic [31:0] unused_tmo_s;
    assign unused_tmo_s = 32'(TIMEOUT_CYCLES);
    assign bus_err      = 1'b0;
`endif

    // Access sequencing: issue, handshake, optional read wait, one free cycle.
    always_comb begin
        state_d     = state_q;
        mem_valid_d = mem_valid_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        size_d      = size_q;
        sgn_d       = sgn_q;
        off_d       = off_q;
`ifdef DMEM_TIMEOUT_EN
        tmo_d       = tmo_q + TMO_W'(1);
        bus_err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (req_s && !mis_s) begin
                    state_d     = REQ;
                    mem_valid_d = 1'b1;
                    mem_we_d    = req_write;
                    mem_be_d    = lane_be_s;
                    mem_addr_d  = {addr[31:2], 2'b00};
                    mem_wdata_d = lane_wdata_s;
                    size_d      = req_size_s;
                    sgn_d       = req_signed;
                    off_d       = addr[1:0];
`ifdef DMEM_TIMEOUT_EN
                    tmo_d       = TMO_W'(0);
`endif
                end else if (req_s) begin
                    rdata_d = RST_RDATA;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (mem_ready) begin
                    mem_valid_d = 1'b0;
`ifdef DMEM_TIMEOUT_EN
                    tmo_d       = TMO_W'(0);
`endif
                    if (mem_we_q) begin
                        state_d = DONE;
                    end else if (mem_rvalid) begin
                        rdata_d = lane_rdata_s;
                        state_d = DONE;
                    end else begin
                        state_d = WAIT_R;
                    end
                end else begin
`ifdef DMEM_TIMEOUT_EN
                    if (tmo_hit_s) begin
                        mem_valid_d = 1'b0;
                        bus_err_d   = 1'b1;
                        state_d     = DONE;
                        if (!mem_we_q) begin
                            rdata_d = BUS_ERR_DATA;
                        end else begin
                            rdata_d = rdata_q;
                        end
                    end else begin
                        state_d = REQ;
                    end
`else
                    state_d = REQ;
`endif
                end
            end
            WAIT_R: begin
                if (mem_rvalid) begin
                    rdata_d = lane_rdata_s;
                    state_d = DONE;
                end else begin
`ifdef DMEM_TIMEOUT_EN
                    if (tmo_hit_s) begin
                        bus_err_d = 1'b1;
                        rdata_d   = BUS_ERR_DATA;
                        state_d   = DONE;
                    end else begin
                        state_d = WAIT_R;
                    end
`else
                    state_d = WAIT_R;
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'b0000;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            rdata_q     <= RST_RDATA;
            size_q      <= SZ_BYTE;
            sgn_q       <= 1'b0;
            off_q       <= 2'b00;
`ifdef DMEM_TIMEOUT_EN
            tmo_q       <= TMO_W'(0);
            bus_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mem_valid_q <= mem_valid_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            size_q      <= size_d;
            sgn_q       <= sgn_d;
            off_q       <= off_d;
`ifdef DMEM_TIMEOUT_EN
            tmo_q       <= tmo_d;
            bus_err_q   <= bus_err_d;
`endif
        end
    end

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Sits directly downstream of the single-cycle datapath.
- Consumes its ALU result (address) and store data, drives a handshaked data-memory bus, and returns load data on the readdata path.
- Supports byte, half and word accesses with byte-lane steering and sign/zero extension.
- Stalls the processor (PC/register-file write enables gated externally) until the access completes.

Parameters:
- TIMEOUT_CYCLES, 64, cycles waited in REQ/WAIT_R before abort; only used with DMEM_TIMEOUT_EN.
- RST_RDATA, 32'h0, reset and misalign value of rdata.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_read  input  1  load in current instruction (memtoreg).
- req_write  input  1  store in current instruction (memwrite).
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- req_signed  input  1  1 = sign-extend loads, 0 = zero-extend.
- addr  input  32  byte address (aluout).
- wdata  input  32  store data, right-justified (writedata).
- rdata  output  32  registered, extended load result (readdata).
- stall  output  1  processor must hold state and inputs.
- misalign  output  1  one-cycle pulse: access rejected.
- bus_err  output  1  one-cycle pulse on timeout abort; tied 0 without the macro.
- mem_valid  output  1  request valid to memory.
- mem_ready  input  1  memory accepts request.
- mem_we  output  1  1 = write.
- mem_be  output  4  byte enables, little-endian lanes.
- mem_addr  output  32  word address, {addr[31:2],2'b00}.
- mem_wdata  output  32  store data replicated into lanes.
- mem_rvalid  input  1  read data valid.
- mem_rdata  input  32  read data word.

Behaviour:
- Reset (asynchronous, active-low): state IDLE.
  - mem_valid, mem_we, mem_be, mem_addr, mem_wdata cleared to 0.
  - rdata = RST_RDATA; misalign = 0; bus_err = 0.
  - Reset mid-transaction aborts immediately: mem_valid drops asynchronously, and any later mem_rvalid/mem_ready is ignored in IDLE.
- req = req_read | req_write. If both are high, the access is a write.
- Alignment: half requires addr[0]=0; word requires addr[1:0]=00.
  - A misaligned access issues no bus cycle.
  - misalign pulses in the request cycle, stall = 0, rdata = RST_RDATA.
- stall = req & !misaligned & (state != DONE). This is combinational.
- FSM:
  - IDLE: on an aligned req, register mem_* outputs and go to REQ. Request-to-bus latency is 1 cycle.
  - REQ: mem_valid = 1, held with stable address/data until mem_ready.
    - On handshake, a write goes to DONE.
    - On handshake, a read goes to WAIT_R; if mem_rvalid arrives in the same cycle, the read goes straight to DONE.
  - WAIT_R: on mem_rvalid, capture the extended lane into rdata and go to DONE.
  - DONE: stall = 0 for exactly one cycle, then IDLE.
  - Minimum latency: write = 2 stall cycles; read = 2 stall cycles with same-cycle rvalid.
- mem_be: byte = 0001 << addr[1:0]; half = 0011 << addr[1:0]; word = 1111.
- mem_wdata: byte = wdata[7:0] replicated to 4 lanes; half = wdata[15:0] replicated to 2 lanes; word = wdata.
- Load extraction: select lane by addr[1:0]; extend to 32 bits per req_signed.
- rdata holds its last value outside load completion.
- mem_rvalid outside WAIT_R/REQ is ignored.

Optional Feature:
- DMEM_TIMEOUT_EN defined:
  - An 8-bit-or-wider counter runs in REQ and WAIT_R and is cleared on each state entry.
  - On reaching TIMEOUT_CYCLES, the FSM drops mem_valid and goes to DONE.
  - bus_err pulses for 1 cycle; a load returns rdata = 32'hDEADBEEF.
- DMEM_TIMEOUT_EN undefined: the FSM waits indefinitely, bus_err is constant 0, and no counter exists.

Decomposition:
- Package dmem_pkg holds:
  - size_t enum (SZ_BYTE, SZ_HALF, SZ_WORD).
  - state_t enum (IDLE, REQ, WAIT_R, DONE).
  - constant BUS_ERR_DATA = 32'hDEADBEEF.
- Sub-module dmem_lane: combinational; produces be/wdata replication and load lane select plus extension from size, signed and addr[1:0].
- The FSM and registers stay in dmem_bridge.

Test Plan:
- Word store: addr=0x100, wdata=0x12345678, mem_ready high in REQ -> mem_be=1111, mem_addr=0x100, mem_wdata=0x12345678, stall high 2 cycles.
- Signed byte load: addr=0x103, mem_rdata=0x80FF0011, req_signed=1 -> rdata=0xFFFFFF80; with req_signed=0 -> rdata=0x00000080.
- Half store: addr=0x22, wdata=0x0000ABCD -> mem_be=1100, mem_wdata=0xABCDABCD; mem_ready delayed 5 cycles -> stall held 6 cycles, address/data stable throughout.
- Misaligned word load: addr=0x101 -> misalign pulse, mem_valid never asserts, stall=0, rdata=0.
- Reset asserted in WAIT_R, then mem_rvalid while reset is released -> mem_valid=0 immediately, state IDLE, rdata unchanged from 0.
- With DMEM_TIMEOUT_EN and TIMEOUT_CYCLES=4: load with mem_ready never asserted -> bus_err pulse after 4 REQ cycles, rdata=0xDEADBEEF, stall drops.
